seq_mul_nb: RTL and testbench

- Parametrised iterative shift-add unsigned multiplier; successor to the fixed 4x4 combinational multipliers (ripple-carry, carry-save and CLA variants).
- Trades area for latency: one partial product per clock.
- Uses valid/ready handshakes on input and output, so it can sit in a stream between producer and consumer stages.
- Exhaustive reference-compare bench is reused at WIDTH=4.

---
 rtl/seq_mul_pkg.sv | 19 +
 rtl/seq_mul_step.sv | 20 ++
 rtl/seq_mul_nb.sv | 111 +++++++++++
 tb/tb_seq_mul_nb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared types and sizing helpers for the iterative multiplier.
// Optional macro SEQ_MUL_EARLY_EXIT_EN is consumed by seq_mul_nb.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// seq_mul_step: one shift-add iteration, purely combinational.
// Reusable as a stage of an unrolled or pipelined multiplier.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] a_o,
  output logic [WIDTH-1:0]   b_o
);

  assign acc_o = b_i[0] ? acc_i + a_i : acc_i;
  assign a_o   = a_i << 1;
  assign b_o   = b_i >> 1;

endmodule

// File: rtl/seq_mul_nb.sv
// seq_mul_nb: iterative shift-add unsigned multiplier, valid/ready streams.
// Define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the multiplier is drained.
module seq_mul_nb
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int CNT_W  = cnt_w(WIDTH);

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [PROD_W-1:0]   a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   out_q, out_d;

  logic [PROD_W-1:0]   acc_nx, a_nx;
  logic [WIDTH-1:0]    b_nx;
  logic                fin;

  seq_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (acc_nx),
    .a_o   (a_nx),
    .b_o   (b_nx)
  );

  // Finishing takes its own edge; early exit needs one iteration first.
`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign fin = (cnt_q == CNT_W'(WIDTH)) ||
               ((cnt_q != '0) && (b_q == '0));
`else
  assign fin = (cnt_q == CNT_W'(WIDTH));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          acc_d   = '0;
          a_d     = {{WIDTH{1'b0}}, in_a};
          b_d     = in_b;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (fin) begin
          state_d = DONE;
          out_d   = acc_q;
        end else begin
          acc_d = acc_nx;
          a_d   = a_nx;
          b_d   = b_nx;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_seq_mul_nb.sv
// tb_seq_mul_nb: directed and random checks of seq_mul_nb at WIDTH 4 and 8.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_seq_mul_nb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] o8;

  logic        iv4, ir4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  o4;

  int errors = 0;
  int checks = 0;

  seq_mul_nb #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .in_a      (a8),
    .in_b      (b8),
    .out_valid (ov8),
    .out_ready (or8),
    .out       (o8)
  );

  seq_mul_nb #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .in_a      (a4),
    .in_b      (b4),
    .out_valid (ov4),
    .out_ready (or4),
    .out       (o4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from accept to out_valid.
  function automatic int lat(input int w, input int b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < w; i++)
      if (b[i]) m = i;
    return m + 2;
`else
    return w + 1;
`endif
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input int hold, input bit scr);
    int n;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    @(negedge clk);
    chk("w8 in_ready idle", 32'(ir8), 1);
    iv8 = 1'b1; a8 = a; b8 = b; or8 = 1'b0;
    @(posedge clk); #1;
    if (!scr) iv8 = 1'b0;
    n = 0;
    do begin
      if (scr) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (!ov8) chk("w8 in_ready busy", 32'(ir8), 0);
    end while (!ov8 && n < 40);
    iv8 = 1'b0;
    chk("w8 latency", n, lat(8, int'(b)));
    chk("w8 product", 32'(o8), 32'(exp));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("w8 hold valid", 32'(ov8), 1);
      chk("w8 hold out", 32'(o8), 32'(exp));
      chk("w8 hold in_ready", 32'(ir8), 0);
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("w8 handoff valid", 32'(ov8), 0);
    chk("w8 handoff in_ready", 32'(ir8), 1);
    chk("w8 out kept", 32'(o8), 32'(exp));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int n;
    @(negedge clk);
    iv4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov4 && n < 20);
    chk("w4 latency", n, lat(4, int'(b)));
    chk("w4 product", 32'(o4), int'(a) * int'(b));
    @(posedge clk); #1;
    chk("w4 handoff valid", 32'(ov4), 0);
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(ov8), 0);
    chk("rst in_ready", 32'(ir8), 1);
    chk("rst out", 32'(o8), 0);
    chk("rst w4 out_valid", 32'(ov4), 0);
    chk("rst w4 in_ready", 32'(ir4), 1);
    chk("rst w4 out", 32'(o4), 0);
    rst = 1'b0;

    or4 = 1'b1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run4(4'(a), 4'(b));
    or4 = 1'b0;

    run8(8'hFF, 8'hFF, 10, 1'b0);
    run8(8'd2, 8'h80, 0, 1'b0);
    run8(8'd55, 8'd0, 1, 1'b0);
    run8(8'd9, 8'd1, 0, 1'b0);

    // Abort mid-operation.
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", 32'(ov8), 0);
    chk("abort out", 32'(o8), 0);
    chk("abort in_ready", 32'(ir8), 1);
    run8(8'd7, 8'd9, 0, 1'b0);

    run8(8'd173, 8'd91, 2, 1'b1);
    for (int i = 0; i < 8; i++)
      run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
           1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
